// File: rtl/avr_boot_pkg.sv
// Shared definitions for the AVR serial boot loader: state encoding, frame
// header byte and the default idle timeout.
package avr_boot_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_LEN_H = 3'd1,
    ST_LEN_L = 3'd2,
    ST_D_LO  = 3'd3,
    ST_D_HI  = 3'd4,
    ST_CSUM  = 3'd5,
    ST_RUN   = 3'd6
  } boot_state_e;

  localparam logic [7:0] HDR_BYTE        = 8'hA5;
  localparam int         DEFAULT_TIMEOUT = 1000;

endpackage

// File: rtl/avr_boot_ctrl.sv
// Boot controller: holds the AVR core in reset, loads a framed program image
// into program memory from a byte stream, then releases the core.
module avr_boot_ctrl
  import avr_boot_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              cpu_reset,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              loading,
  output logic              err
);

  localparam int                TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TMO_ONE  = TW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  boot_state_e       state_r, state_nxt_s;
  logic [TW-1:0]     tmo_cnt_r;
  logic [7:0]        len_hi_r;
  logic [15:0]       words_left_r;
  logic [7:0]        lo_r;
  logic [7:0]        sum_r;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic              cpu_reset_r, pm_we_r, err_r;
  logic [ADDR_W-1:0] pm_addr_r;
  logic [15:0]       pm_wdata_r;
  logic              take_s, hdr_s, wr_s, data_s, csum_bad_s;

  // rx_ready depends on state only so the source never sees a valid->ready loop.
  assign rx_ready  = (state_r != ST_RUN);
  assign loading   = (state_r != ST_RUN);
  assign cpu_reset = cpu_reset_r;
  assign pm_we     = pm_we_r;
  assign pm_addr   = pm_addr_r;
  assign pm_wdata  = pm_wdata_r;
  assign err       = err_r;

  // Next-state decode and per-byte event strobes.
  always_comb begin
    state_nxt_s = state_r;
    take_s      = rx_valid && rx_ready;
    hdr_s       = 1'b0;
    wr_s        = 1'b0;
    data_s      = 1'b0;
    csum_bad_s  = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (take_s && (rx_data == HDR_BYTE)) begin
          state_nxt_s = ST_LEN_H;
          hdr_s       = 1'b1;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_LEN_H: begin
        if (take_s) state_nxt_s = ST_LEN_L;
        else        state_nxt_s = ST_LEN_H;
      end
      ST_LEN_L: begin
        if (take_s && ({len_hi_r, rx_data} == 16'd0)) state_nxt_s = ST_CSUM;
        else if (take_s)                              state_nxt_s = ST_D_LO;
        else                                          state_nxt_s = ST_LEN_L;
      end
      ST_D_LO: begin
        data_s = take_s;
        if (take_s) state_nxt_s = ST_D_HI;
        else        state_nxt_s = ST_D_LO;
      end
      ST_D_HI: begin
        data_s = take_s;
        wr_s   = take_s;
        if (take_s && (words_left_r == 16'd1)) state_nxt_s = ST_CSUM;
        else if (take_s)                       state_nxt_s = ST_D_LO;
        else                                   state_nxt_s = ST_D_HI;
      end
      ST_CSUM: begin
        if (take_s && (rx_data == sum_r)) begin
          state_nxt_s = ST_RUN;
        end else if (take_s) begin
          state_nxt_s = ST_WAIT;
          csum_bad_s  = 1'b1;
        end else begin
          state_nxt_s = ST_CSUM;
        end
      end
      ST_RUN: begin
        if (reload) state_nxt_s = ST_WAIT;
        else        state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_WAIT;
    endcase
  end

  // State, counters, checksum and registered program-memory/control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_WAIT;
      tmo_cnt_r    <= '0;
      len_hi_r     <= 8'd0;
      words_left_r <= 16'd0;
      lo_r         <= 8'd0;
      sum_r        <= 8'd0;
      addr_cnt_r   <= '0;
      cpu_reset_r  <= 1'b1;
      pm_we_r      <= 1'b0;
      pm_addr_r    <= '0;
      pm_wdata_r   <= 16'd0;
      err_r        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cpu_reset_r <= (state_nxt_s != ST_RUN);
      pm_we_r     <= wr_s;
      // Counter runs only while WAIT persists; any entry into WAIT restarts it.
      if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
      else                                                  tmo_cnt_r <= '0;
      if (state_r == ST_LEN_H && take_s) len_hi_r <= rx_data;
      else                               len_hi_r <= len_hi_r;
      if (state_r == ST_LEN_L && take_s) words_left_r <= {len_hi_r, rx_data};
      else if (wr_s)                     words_left_r <= words_left_r - 16'd1;
      else                               words_left_r <= words_left_r;
      if (state_r == ST_D_LO && take_s) lo_r <= rx_data;
      else                              lo_r <= lo_r;
      if (hdr_s)       sum_r <= 8'd0;
      else if (data_s) sum_r <= sum_r + rx_data;
      else             sum_r <= sum_r;
      if (hdr_s)     addr_cnt_r <= '0;
      else if (wr_s) addr_cnt_r <= addr_cnt_r + ADDR_ONE;
      else           addr_cnt_r <= addr_cnt_r;
      if (wr_s) begin
        pm_addr_r  <= addr_cnt_r;
        pm_wdata_r <= {rx_data, lo_r};
      end else begin
        pm_addr_r  <= pm_addr_r;
        pm_wdata_r <= pm_wdata_r;
      end
      if (hdr_s)           err_r <= 1'b0;
      else if (csum_bad_s) err_r <= 1'b1;
      else                 err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_avr_boot_ctrl.sv
// Directed self-checking bench for avr_boot_ctrl with a short timeout and a
// 3-bit address space so that timeout and address wrap are reachable quickly.
module tb_avr_boot_ctrl;

  localparam int ADDR_W  = 3;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              reload = 1'b0;
  logic              cpu_reset;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [15:0]       pm_wdata;
  logic              loading;
  logic              err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [15:0]       wd[$];

  avr_boot_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .cpu_reset(cpu_reset),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .loading(loading), .err(err)
  );

  always #5 clk = ~clk;

  // Record every program-memory write, sampled away from the rising edge.
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      wa.push_back(pm_addr);
      wd.push_back(pm_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wa.delete(); wd.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (cpu_reset !== 1'b1) begin n_fails++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    n_checks++; if (pm_we !== 1'b0) begin n_fails++; $display("FAIL reset_pm_we: got %b want 0", pm_we); end
    n_checks++; if (pm_addr !== 3'd0) begin n_fails++; $display("FAIL reset_pm_addr: got %0d want 0", pm_addr); end
    n_checks++; if (pm_wdata !== 16'h0000) begin n_fails++; $display("FAIL reset_pm_wdata: got %h want 0000", pm_wdata); end
    n_checks++; if (err !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if ({loading, rx_ready} !== 2'b11) begin n_fails++; $display("FAIL reset_loading_ready: got %b want 11", {loading, rx_ready}); end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'h11);               // non-header byte: discarded, count keeps running
    repeat (TIMEOUT - 2) @(negedge clk);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fails++; $display("FAIL timeout_before: got cpu_reset %b want 1 at edge %0d", cpu_reset, TIMEOUT - 1); end
    @(negedge clk);
    n_checks++; if (cpu_reset !== 1'b0) begin n_fails++; $display("FAIL timeout_at: got cpu_reset %b want 0 at edge %0d", cpu_reset, TIMEOUT); end
    n_checks++; if ({loading, rx_ready} !== 2'b00) begin n_fails++; $display("FAIL timeout_run_outputs: got %b want 00", {loading, rx_ready}); end
    rx_data = 8'hA5; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    n_checks++; if (loading !== 1'b0) begin n_fails++; $display("FAIL run_ignores_bytes: got loading %b want 0", loading); end
    n_checks++; if (wa.size() !== 0) begin n_fails++; $display("FAIL timeout_no_writes: got %0d writes want 0", wa.size()); end
  endtask

  task automatic test_good_frame();
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02);
    repeat (2 * TIMEOUT) @(negedge clk);   // mid-frame stall longer than the timeout
    n_checks++; if ({loading, cpu_reset} !== 2'b11) begin n_fails++; $display("FAIL stall_holds: got %b want 11", {loading, cpu_reset}); end
    send(8'h0C); send(8'h94);
    n_checks++; if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 3'd0, 16'h940C}) begin n_fails++; $display("FAIL word0_strobe: got we=%b addr=%0d data=%h want 1/0/940C", pm_we, pm_addr, pm_wdata); end
    send(8'hFF);
    n_checks++; if (pm_we !== 1'b0) begin n_fails++; $display("FAIL we_single_cycle: got %b want 0", pm_we); end
    send(8'hCF);
    send(8'h6E);               // 0C+94+FF+CF mod 256
    n_checks++; if (wa.size() !== 2) begin n_fails++; $display("FAIL good_write_count: got %0d want 2", wa.size()); end
    n_checks++; if ({wa[1], wd[1]} !== {3'd1, 16'hCFFF}) begin n_fails++; $display("FAIL good_word1: got %0d/%h want 1/CFFF", wa[1], wd[1]); end
    n_checks++; if ({cpu_reset, loading, err} !== 3'b000) begin n_fails++; $display("FAIL good_run: got cpu_reset/loading/err %b want 000", {cpu_reset, loading, err}); end
  endtask

  task automatic test_reload();
    pulse_reload();
    n_checks++; if ({cpu_reset, loading} !== 2'b11) begin n_fails++; $display("FAIL reload_next_cycle: got %b want 11", {cpu_reset, loading}); end
    wa.delete(); wd.delete();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h34); send(8'h12); send(8'h46);
    n_checks++; if (wa.size() !== 1 || wa[0] !== 3'd0 || wd[0] !== 16'h1234) begin n_fails++; $display("FAIL reload_frame: got n=%0d addr=%0d data=%h want 1/0/1234", wa.size(), wa[0], wd[0]); end
    n_checks++; if (cpu_reset !== 1'b0) begin n_fails++; $display("FAIL reload_run: got cpu_reset %b want 0", cpu_reset); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h0C); send(8'h94); send(8'hFF); send(8'hCF);
    send(8'h00);
    n_checks++; if ({err, cpu_reset, loading, rx_ready} !== 4'b1111) begin n_fails++; $display("FAIL bad_csum: got err/cpu_reset/loading/ready %b want 1111", {err, cpu_reset, loading, rx_ready}); end
    pulse_reload();            // ignored outside RUN
    repeat (TIMEOUT - 2) @(negedge clk);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fails++; $display("FAIL bad_tmo_restart: got cpu_reset %b want 1", cpu_reset); end
    @(negedge clk);
    n_checks++; if ({cpu_reset, err} !== 2'b01) begin n_fails++; $display("FAIL bad_tmo_run: got cpu_reset/err %b want 01", {cpu_reset, err}); end
    pulse_reload();
    send(8'hA5);
    n_checks++; if (err !== 1'b0) begin n_fails++; $display("FAIL err_clear_on_hdr: got %b want 0", err); end
    send(8'h00); send(8'h02); send(8'h0C); send(8'h94); send(8'hFF); send(8'hCF); send(8'h6E);
    n_checks++; if ({cpu_reset, err} !== 2'b00) begin n_fails++; $display("FAIL good_after_bad: got cpu_reset/err %b want 00", {cpu_reset, err}); end
  endtask

  task automatic test_zero_len();
    do_reset();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    n_checks++; if ({cpu_reset, loading, err} !== 3'b000) begin n_fails++; $display("FAIL zero_len_run: got %b want 000", {cpu_reset, loading, err}); end
    n_checks++; if (wa.size() !== 0) begin n_fails++; $display("FAIL zero_len_writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h22); send(8'h11); send(8'h33);
    pulse_reload();
    wa.delete(); wd.delete();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h0C);
    n_checks++; if (pm_addr !== 3'd0 || pm_wdata !== 16'h1122) begin n_fails++; $display("FAIL pre_abort_regs: got %0d/%h want 0/1122", pm_addr, pm_wdata); end
    reset = 1'b0;
    #1;
    n_checks++; if ({pm_we, cpu_reset, err, pm_wdata} !== {3'b010, 16'h0000}) begin n_fails++; $display("FAIL abort_async: got we/cpu_reset/err=%b data=%h want 010/0000", {pm_we, cpu_reset, err}, pm_wdata); end
    @(negedge clk);
    reset = 1'b1;
    send(8'h94);               // would have completed a word; now a stray byte in WAIT
    repeat (2) @(negedge clk);
    n_checks++; if (wa.size() !== 0 || pm_addr !== 3'd0 || cpu_reset !== 1'b1) begin n_fails++; $display("FAIL abort_after: got writes=%0d addr=%0d cpu_reset=%b want 0/0/1", wa.size(), pm_addr, cpu_reset); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    send(8'hA5); send(8'h00); send(8'h09);
    for (int i = 1; i <= 9; i++) begin
      send(8'(i)); send(8'h10);
    end
    send(8'hBD);               // (1+..+9) + 9*0x10 = 189
    n_checks++; if (wa.size() !== 9) begin n_fails++; $display("FAIL wrap_count: got %0d want 9", wa.size()); end
    n_checks++; if ({wa[7], wd[7]} !== {3'd7, 16'h1008}) begin n_fails++; $display("FAIL wrap_last: got %0d/%h want 7/1008", wa[7], wd[7]); end
    n_checks++; if ({wa[8], wd[8]} !== {3'd0, 16'h1009}) begin n_fails++; $display("FAIL wrap_first: got %0d/%h want 0/1009", wa[8], wd[8]); end
    n_checks++; if ({cpu_reset, err} !== 2'b00) begin n_fails++; $display("FAIL wrap_run: got %b want 00", {cpu_reset, err}); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_good_frame();
    test_reload();
    test_bad_checksum();
    test_zero_len();
    test_reset_midframe();
    test_back_to_back_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
